demux_8bits_stream: RTL and testbench
=====================================

DEMUX_8BITS_STREAM -- requirements
Module: demux_8bits_stream

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning data word width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 2, meaning entries per output FIFO; legal values are powers of two, 2 or more.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state changes occur on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 The block SHALL have port in_valid  input  1  upstream word present.
REQ-006 The block SHALL have port in_ready  output  1  the block accepts the word this cycle.
REQ-007 The block SHALL have port in_data  input  WIDTH  upstream word.
REQ-008 The block SHALL have port in_sel  input  1  destination select: 0 routes to output A, 1 routes to output B.
REQ-009 The block SHALL have ports a_valid  output  1, a_ready  input  1 and a_data  output  WIDTH, forming downstream channel A.
REQ-010 The block SHALL have ports b_valid  output  1, b_ready  input  1 and b_data  output  WIDTH, forming downstream channel B.
REQ-011 The block SHALL have ports a_count and b_count  output  $clog2(DEPTH)+1  current occupancy of each FIFO.

Function
REQ-012 An input transfer SHALL occur on a rising edge where in_valid=1 and in_ready=1; the word SHALL be written to the FIFO chosen by in_sel sampled at that edge.
REQ-013 in_ready SHALL be combinational: 1 when the FIFO selected by the current in_sel holds fewer than DEPTH entries, 0 otherwise.
REQ-014 in_ready SHALL be 0 when the selected FIFO is full, even if that FIFO pops in the same cycle; there is no full-path bypass.
REQ-015 An output transfer on a channel SHALL occur on a rising edge where x_valid=1 and x_ready=1, removing the head entry.
REQ-016 x_valid SHALL equal (x_count != 0); x_data SHALL equal the FIFO head when x_valid=1 and all zeros when x_valid=0.
REQ-017 A word accepted at edge N SHALL first be visible on its output after edge N; the latency is 1 cycle, with no combinational input-to-output path.
REQ-018 Each FIFO SHALL preserve arrival order; read and write pointers SHALL wrap modulo DEPTH with no data loss or duplication.
REQ-019 A simultaneous push and pop on the same FIFO, legal only when not full, SHALL leave the count unchanged and advance both pointers.
REQ-020 The two FIFOs SHALL be independent: a full, stalled channel SHALL NOT block traffic destined for the other channel.
REQ-021 A pop on an empty FIFO SHALL NOT be possible because x_valid=0; x_ready SHALL be ignored while x_valid=0.
REQ-022 x_count SHALL change by at most 1 per edge and SHALL never exceed DEPTH.
REQ-023 in_valid=0 SHALL leave the FIFO contents untouched regardless of in_sel and in_data.

Reset
REQ-024 When rst_n=0, the block SHALL immediately, without waiting for clk, empty both FIFOs: pointers to 0, a_count=b_count=0, a_valid=b_valid=0, a_data=b_data=0.
REQ-025 in_ready SHALL be 1 during reset; no transfer SHALL occur on any edge while rst_n=0.
REQ-026 Reset asserted mid-operation SHALL discard all buffered words; after release, only words accepted after release SHALL appear on the outputs.
REQ-027 Storage array contents SHALL NOT need reset; that data SHALL NOT be observable because of REQ-016.

Verification
REQ-028 The bench SHALL cover reset: rst_n=0 with any inputs -> a_valid=b_valid=0, a_count=b_count=0, a_data=b_data=8'h00, in_ready=1.
REQ-029 The bench SHALL cover single route: push 8'h01 with in_sel=0 and a_ready=0 -> after the next edge a_valid=1, a_data=8'h01, a_count=1, and b_valid stays 0.
REQ-030 The bench SHALL cover full and independence: push 8'h11 then 8'h22 to A with a_ready=0 -> a_count=2 and in_ready=0 for in_sel=0; switch in_sel=1 -> in_ready=1, push 8'hFF -> b_data=8'hFF, b_count=1.
REQ-031 The bench SHALL cover wrap and order: stream 8'h01, 8'h02 through 8'h80, then 8'hFF, to A each cycle with a_ready=1 -> a_data shows the same sequence delayed 1 cycle, and a_count holds 1 throughout.
REQ-032 The bench SHALL cover simultaneous push and pop: with A holding 8'h01 (count 1), push 8'h02 with a_ready=1 -> count stays 1 and a_data becomes 8'h02.
REQ-033 The bench SHALL cover reset mid-operation: with A holding 2 entries, drop rst_n between edges -> a_valid falls at once; after release push 8'h55 -> a_data=8'h55 with a_count=1.

Source files
------------

// File: rtl/demux_8bits_stream.sv
// demux_8bits_stream
// Routes an upstream ready/valid word stream to one of two independent
// downstream ready/valid channels (A or B). Each channel has its own
// DEPTH-entry FIFO, so a stalled channel never blocks the other one.
// Output data is zero whenever a channel has nothing to present.
module demux_8bits_stream #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    input  logic                       in_sel,
    output logic                       a_valid,
    input  logic                       a_ready,
    output logic [WIDTH-1:0]           a_data,
    output logic                       b_valid,
    input  logic                       b_ready,
    output logic [WIDTH-1:0]           b_data,
    output logic [$clog2(DEPTH):0]     a_count,
    output logic [$clog2(DEPTH):0]     b_count
);

    // Pointer width addresses DEPTH entries; the count needs one more bit
    // so that a completely full FIFO (count == DEPTH) is representable.
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_LEVEL = CW'(DEPTH);

    // Per-channel views: index 0 is channel A, index 1 is channel B.
    logic [1:0]       ch_ready;
    logic [1:0]       ch_valid;
    logic [1:0]       ch_full;
    logic [WIDTH-1:0] ch_data  [2];
    logic [CW-1:0]    ch_count [2];

    assign ch_ready[0] = a_ready;
    assign ch_ready[1] = b_ready;

    // Ready depends only on the FIFO the current select points at; a pop in
    // the same cycle does not free the slot early. While reset is held all
    // counts are zero, so ready naturally reads 1.
    assign in_ready = in_sel ? ~ch_full[1] : ~ch_full[0];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi = gi + 1) begin : g_chan
            logic [WIDTH-1:0] mem [DEPTH];
            logic [PW-1:0]    wr_ptr_reg;
            logic [PW-1:0]    rd_ptr_reg;
            logic [CW-1:0]    count_reg;
            logic [PW-1:0]    wr_ptr_next;
            logic [PW-1:0]    rd_ptr_next;
            logic [CW-1:0]    count_next;
            logic             push;
            logic             pop;

            assign ch_full[gi]  = (count_reg == FULL_LEVEL);
            assign ch_valid[gi] = (count_reg != '0);

            // A write targets this channel only when it is selected and has
            // room; the rst_n term keeps the storage frozen while in reset.
            assign push = rst_n & in_valid & (in_sel == 1'(gi)) & ~ch_full[gi];
            // A pop needs a valid head, so ready is ignored on an empty FIFO.
            assign pop  = ch_valid[gi] & ch_ready[gi];

            // Next-state pointers and occupancy; push and pop together keep
            // the count while both pointers advance.
            always_comb begin
                wr_ptr_next = wr_ptr_reg;
                rd_ptr_next = rd_ptr_reg;
                count_next  = count_reg;
                if (push) begin
                    wr_ptr_next = (DEPTH > 1) ? wr_ptr_reg + PW'(1) : '0;
                end
                if (pop) begin
                    rd_ptr_next = (DEPTH > 1) ? rd_ptr_reg + PW'(1) : '0;
                end
                case ({push, pop})
                    2'b10:   count_next = count_reg + CW'(1);
                    2'b01:   count_next = count_reg - CW'(1);
                    default: count_next = count_reg;
                endcase
            end

            // Control state clears asynchronously, discarding buffered words.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    count_reg  <= '0;
                end else begin
                    wr_ptr_reg <= wr_ptr_next;
                    rd_ptr_reg <= rd_ptr_next;
                    count_reg  <= count_next;
                end
            end

            // Storage is never reset; stale words are hidden by valid gating.
            always_ff @(posedge clk) begin
                if (push) begin
                    mem[wr_ptr_reg] <= in_data;
                end
            end

            assign ch_count[gi] = count_reg;
            assign ch_data[gi]  = ch_valid[gi] ? mem[rd_ptr_reg] : '0;
        end
    endgenerate

    assign a_valid = ch_valid[0];
    assign b_valid = ch_valid[1];
    assign a_data  = ch_data[0];
    assign b_data  = ch_data[1];
    assign a_count = ch_count[0];
    assign b_count = ch_count[1];

endmodule

// File: tb/tb_demux_8bits_stream.sv
// Testbench for demux_8bits_stream: directed scenarios followed by random
// traffic. A monitor keeps per-channel queues of accepted words as the
// reference and compares every cycle and on every output transfer.
module tb_demux_8bits_stream;

    localparam int WIDTH = 8;
    localparam int DEPTH = 2;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_sel;
    logic             a_valid;
    logic             a_ready;
    logic [WIDTH-1:0] a_data;
    logic             b_valid;
    logic             b_ready;
    logic [WIDTH-1:0] b_data;
    logic [CW-1:0]    a_count;
    logic [CW-1:0]    b_count;

    int vectors    = 0;
    int miscompares = 0;

    // Reference contents of each FIFO, oldest first.
    logic [WIDTH-1:0] qa [$];
    logic [WIDTH-1:0] qb [$];

    demux_8bits_stream #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .a_data   (a_data),
        .b_valid  (b_valid),
        .b_ready  (b_ready),
        .b_data   (b_data),
        .a_count  (a_count),
        .b_count  (b_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Monitor: checks outputs against the queues mid-cycle, then applies the
    // transfers that the rising edge performs.
    initial begin : monitor
        bit do_push, do_pop_a, do_pop_b, sel;
        logic [WIDTH-1:0] word;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                qa.delete();
                qb.delete();
            end
            chk("a_count", int'(a_count), qa.size());
            chk("b_count", int'(b_count), qb.size());
            chk("a_valid", int'(a_valid), int'(qa.size() != 0));
            chk("b_valid", int'(b_valid), int'(qb.size() != 0));
            chk("a_data",  int'(a_data),  (qa.size() != 0) ? int'(qa[0]) : 0);
            chk("b_data",  int'(b_data),  (qb.size() != 0) ? int'(qb[0]) : 0);
            chk("in_ready", int'(in_ready),
                int'(in_sel ? (qb.size() < DEPTH) : (qa.size() < DEPTH)));
            sel      = in_sel;
            word     = in_data;
            do_push  = in_valid && (sel ? (qb.size() < DEPTH) : (qa.size() < DEPTH));
            do_pop_a = a_ready && (qa.size() != 0);
            do_pop_b = b_ready && (qb.size() != 0);
            @(posedge clk);
            if (!rst_n) begin
                qa.delete();
                qb.delete();
            end else begin
                if (do_pop_a) chk("a_pop_data", int'(a_data), int'(qa.pop_front()));
                if (do_pop_b) chk("b_pop_data", int'(b_data), int'(qb.pop_front()));
                if (do_push) begin
                    if (sel) qb.push_back(word);
                    else     qa.push_back(word);
                end
            end
        end
    end

    initial begin : stimulus
        logic [WIDTH-1:0] w;
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_sel   = 1'($urandom);
        in_data  = 8'($urandom);
        a_ready  = 1'b1;
        b_ready  = 1'b1;
        #1;
        // Reset with arbitrary inputs: everything empty, ready high.
        chk("rst a_valid", int'(a_valid), 0);
        chk("rst b_valid", int'(b_valid), 0);
        chk("rst a_count", int'(a_count), 0);
        chk("rst b_count", int'(b_count), 0);
        chk("rst a_data",  int'(a_data),  0);
        chk("rst b_data",  int'(b_data),  0);
        chk("rst in_ready", int'(in_ready), 1);
        repeat (3) cycle();
        chk("rst hold a_count", int'(a_count), 0);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        a_ready  = 1'b0;
        b_ready  = 1'b0;
        cycle();

        // Single route to A.
        in_valid = 1'b1; in_sel = 1'b0; in_data = 8'h01;
        cycle();
        in_valid = 1'b0;
        chk("route a_valid", int'(a_valid), 1);
        chk("route a_data",  int'(a_data),  8'h01);
        chk("route a_count", int'(a_count), 1);
        chk("route b_valid", int'(b_valid), 0);

        // Simultaneous push and pop keeps the count.
        in_valid = 1'b1; in_data = 8'h02; a_ready = 1'b1;
        cycle();
        in_valid = 1'b0;
        chk("pushpop a_count", int'(a_count), 1);
        chk("pushpop a_data",  int'(a_data),  8'h02);
        cycle();
        a_ready = 1'b0;
        chk("drain a_count", int'(a_count), 0);

        // Fill A, then show B still accepts.
        in_valid = 1'b1; in_sel = 1'b0; in_data = 8'h11;
        cycle();
        in_data = 8'h22;
        cycle();
        in_valid = 1'b0;
        chk("full a_count", int'(a_count), 2);
        chk("full in_ready", int'(in_ready), 0);
        in_sel = 1'b1;
        #1;
        chk("indep in_ready", int'(in_ready), 1);
        in_valid = 1'b1; in_data = 8'hFF;
        cycle();
        in_valid = 1'b0;
        chk("indep b_data",  int'(b_data),  8'hFF);
        chk("indep b_count", int'(b_count), 1);
        chk("indep a_data",  int'(a_data),  8'h11);

        // Reset between edges with A holding two words.
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst a_valid", int'(a_valid), 0);
        chk("midrst a_count", int'(a_count), 0);
        chk("midrst b_valid", int'(b_valid), 0);
        cycle();
        rst_n = 1'b1;
        in_valid = 1'b1; in_sel = 1'b0; in_data = 8'h55;
        cycle();
        in_valid = 1'b0;
        chk("post rst a_data",  int'(a_data),  8'h55);
        chk("post rst a_count", int'(a_count), 1);
        a_ready = 1'b1; b_ready = 1'b1;
        cycle();

        // Streaming through A wraps the pointers and preserves order.
        for (int i = 0; i < 9; i++) begin
            w = (i < 8) ? 8'(1 << i) : 8'hFF;
            in_valid = 1'b1; in_sel = 1'b0; in_data = w;
            cycle();
            chk("stream a_data",  int'(a_data),  int'(w));
            chk("stream a_count", int'(a_count), 1);
        end
        in_valid = 1'b0;
        cycle();

        // Random traffic with occasional short resets.
        for (int i = 0; i < 3000; i++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_sel   = 1'($urandom);
            in_data  = 8'($urandom);
            a_ready  = ($urandom_range(0, 2) != 0);
            b_ready  = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 299) == 0) begin
                #3;
                rst_n = 1'b0;
                cycle();
                rst_n = 1'b1;
            end else begin
                cycle();
            end
        end
        in_valid = 1'b0;
        a_ready  = 1'b1;
        b_ready  = 1'b1;
        repeat (DEPTH + 2) cycle();
        chk("final a_count", int'(a_count), 0);
        chk("final b_count", int'(b_count), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
